// File: rtl/avalon_mem_responder_if.sv
// Avalon-MM s0 bus between the cache's m0 master and the memory responder.
interface avalon_mem_responder_if;
    logic [27:0] avs_s0_address;
    logic        avs_s0_read;
    logic        avs_s0_write;
    logic [31:0] avs_s0_writedata;
    logic [31:0] avs_s0_readdata;
    logic        avs_s0_waitrequest;

    modport master (
        output avs_s0_address, avs_s0_read, avs_s0_write, avs_s0_writedata,
        input  avs_s0_readdata, avs_s0_waitrequest
    );

    modport slave (
        input  avs_s0_address, avs_s0_read, avs_s0_write, avs_s0_writedata,
        output avs_s0_readdata, avs_s0_waitrequest
    );
endinterface

// File: rtl/avalon_mem_responder.sv
// Avalon-MM slave RAM with programmable stall before each response and a
// sticky flag for requests that change while stalled.
module avalon_mem_responder #(
    parameter int unsigned ADDR_BITS   = 12,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    avalon_mem_responder_if.slave  s0,
    output logic                   protocol_error
);
    localparam int unsigned DEPTH = 1 << ADDR_BITS;

    typedef enum logic [1:0] {IDLE, BUSY, RESPOND} state_t;

    state_t                 state;
    logic [7:0]             count;
    logic                   lat_read;
    logic                   lat_write;
    logic [27:0]            lat_addr;
    logic [31:0]            lat_data;
    logic [31:0]            mem [DEPTH];

    logic                   req;
    logic                   unstable;
    logic                   enter_respond;
    logic                   acc_write;
    logic [ADDR_BITS-1:0]   acc_idx;
    logic [31:0]            acc_data;

    assign req = s0.avs_s0_read | s0.avs_s0_write;

    assign unstable = (s0.avs_s0_read != lat_read) ||
                      (s0.avs_s0_write != lat_write) ||
                      (s0.avs_s0_address != lat_addr) ||
                      (lat_write && (s0.avs_s0_writedata != lat_data));

    // With zero wait the access happens on the sampling edge, so it must use
    // the live bus rather than the not-yet-latched request.
    always_comb begin
        enter_respond = 1'b0;
        acc_write     = lat_write;
        acc_idx       = lat_addr[ADDR_BITS-1:0];
        acc_data      = lat_data;
        case (state)
            IDLE: begin
                if (req && (WAIT_CYCLES == 0)) begin
                    enter_respond = 1'b1;
                    acc_write     = s0.avs_s0_write;
                    acc_idx       = s0.avs_s0_address[ADDR_BITS-1:0];
                    acc_data      = s0.avs_s0_writedata;
                end
            end
            BUSY: begin
                if (count == 8'd1) begin
                    enter_respond = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state                 <= IDLE;
            count                 <= '0;
            lat_read              <= 1'b0;
            lat_write             <= 1'b0;
            lat_addr              <= '0;
            lat_data              <= '0;
            s0.avs_s0_waitrequest <= 1'b1;
            s0.avs_s0_readdata    <= '0;
            protocol_error        <= 1'b0;
        end else begin
            s0.avs_s0_waitrequest <= ~enter_respond;
            if (enter_respond && !acc_write) begin
                s0.avs_s0_readdata <= mem[acc_idx];
            end
            case (state)
                IDLE: begin
                    if (req) begin
                        lat_read  <= s0.avs_s0_read;
                        lat_write <= s0.avs_s0_write;
                        lat_addr  <= s0.avs_s0_address;
                        lat_data  <= s0.avs_s0_writedata;
                        count     <= 8'(WAIT_CYCLES);
                        if (s0.avs_s0_read && s0.avs_s0_write) begin
                            protocol_error <= 1'b1;
                        end
                        state <= (WAIT_CYCLES == 0) ? RESPOND : BUSY;
                    end
                end
                BUSY: begin
                    count <= count - 8'd1;
                    if (unstable) begin
                        protocol_error <= 1'b1;
                    end
                    if (count == 8'd1) begin
                        state <= RESPOND;
                    end
                end
                RESPOND: begin
                    if (unstable) begin
                        protocol_error <= 1'b1;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // RAM is not reset; a write still pending when reset hits is dropped.
    always_ff @(posedge clk) begin
        if (!reset && enter_respond && acc_write) begin
            mem[acc_idx] <= acc_data;
        end
    end
endmodule

// File: tb/tb_avalon_mem_responder.sv
// Randomized and directed checks of avalon_mem_responder (WAIT_CYCLES 2 and 0)
// against a transaction-level memory model.
module tb_avalon_mem_responder;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic err_a;
    logic err_b;

    int n_cmp = 0;
    int n_err = 0;

    avalon_mem_responder_if ifa ();
    avalon_mem_responder_if ifb ();

    avalon_mem_responder #(.ADDR_BITS(12), .WAIT_CYCLES(2)) dut_a (
        .clk(clk), .reset(reset), .s0(ifa.slave), .protocol_error(err_a)
    );
    avalon_mem_responder #(.ADDR_BITS(12), .WAIT_CYCLES(0)) dut_b (
        .clk(clk), .reset(reset), .s0(ifb.slave), .protocol_error(err_b)
    );

    always #5 clk = ~clk;

    logic [31:0] ref_mem [2][4096];
    bit          ref_ok  [2][4096];
    logic [31:0] ref_rd  [2];
    bit          ref_err [2];
    int          wait_of [2];
    logic [11:0] pool    [16];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input int sel, input logic rd, input logic wr,
                         input logic [27:0] a, input logic [31:0] d);
        if (sel == 0) begin
            ifa.avs_s0_read = rd; ifa.avs_s0_write = wr;
            ifa.avs_s0_address = a; ifa.avs_s0_writedata = d;
        end else begin
            ifb.avs_s0_read = rd; ifb.avs_s0_write = wr;
            ifb.avs_s0_address = a; ifb.avs_s0_writedata = d;
        end
    endtask

    function automatic logic get_wait(input int sel);
        return (sel == 0) ? ifa.avs_s0_waitrequest : ifb.avs_s0_waitrequest;
    endfunction

    function automatic logic [31:0] get_rdata(input int sel);
        return (sel == 0) ? ifa.avs_s0_readdata : ifb.avs_s0_readdata;
    endfunction

    function automatic logic get_err(input int sel);
        return (sel == 0) ? err_a : err_b;
    endfunction

    // One master transaction; optionally moves the address one cycle into the stall.
    task automatic txn(input int sel, input logic rd, input logic wr,
                       input logic [27:0] a, input logic [31:0] d,
                       input bit perturb, input logic [27:0] pa);
        int          n = 0;
        bit          done = 0;
        logic [31:0] rdv = '0;
        logic [11:0] idx;
        @(negedge clk);
        drive(sel, rd, wr, a, d);
        while (!done && n < 300) begin
            @(posedge clk);
            #1;
            n++;
            if (perturb && n == 1) drive(sel, rd, wr, pa, d);
            if (!get_wait(sel)) begin
                done = 1;
                rdv  = get_rdata(sel);
            end
        end
        check($sformatf("latency[%0d]", sel), n, wait_of[sel] + 1);
        idx = a[11:0];
        if (rd && wr) ref_err[sel] = 1;
        if (perturb && pa != a) ref_err[sel] = 1;
        if (wr) begin
            ref_mem[sel][idx] = d;
            ref_ok[sel][idx]  = 1;
            check($sformatf("rdata_held[%0d]", sel), rdv, ref_rd[sel]);
        end else if (ref_ok[sel][idx]) begin
            ref_rd[sel] = ref_mem[sel][idx];
            check($sformatf("rdata[%0d] @%h", sel, a), rdv, ref_rd[sel]);
        end
        @(posedge clk);
        #1;
        drive(sel, 1'b0, 1'b0, '0, '0);
        check($sformatf("wait_after[%0d]", sel), {31'b0, get_wait(sel)}, 32'd1);
        check($sformatf("perr[%0d]", sel), {31'b0, get_err(sel)}, {31'b0, ref_err[sel]});
    endtask

    initial begin
        logic [31:0] d10;
        wait_of[0] = 2;
        wait_of[1] = 0;
        for (int s = 0; s < 2; s++) begin
            ref_rd[s]  = '0;
            ref_err[s] = 0;
            for (int i = 0; i < 4096; i++) ref_ok[s][i] = 0;
        end
        drive(0, 1'b0, 1'b0, '0, '0);
        drive(1, 1'b0, 1'b0, '0, '0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Idle after reset
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            for (int s = 0; s < 2; s++) begin
                check("idle_wait", {31'b0, get_wait(s)}, 32'd1);
                check("idle_rdata", get_rdata(s), 32'h0);
                check("idle_perr", {31'b0, get_err(s)}, 32'd0);
            end
        end

        txn(0, 1'b0, 1'b1, 28'h0001000, 32'hDEADBEEF, 0, '0);
        txn(0, 1'b1, 1'b0, 28'h0001000, '0, 0, '0);

        txn(1, 1'b0, 1'b1, 28'h5, 32'h11111111, 0, '0);
        txn(1, 1'b0, 1'b1, 28'h0001005, 32'h22222222, 0, '0);
        txn(1, 1'b1, 1'b0, 28'h5, '0, 0, '0);

        // Randomized traffic on both instances, upper address bits random
        for (int k = 0; k < 16; k++) begin
            pool[k] = 12'($urandom());
            for (int s = 0; s < 2; s++)
                txn(s, 1'b0, 1'b1, {16'($urandom()), pool[k]}, $urandom(), 0, '0);
        end
        for (int i = 0; i < 60; i++) begin
            int s;
            bit rd;
            s  = int'($urandom_range(0, 1));
            rd = 1'($urandom_range(0, 1));
            txn(s, rd, !rd, {16'($urandom()), pool[$urandom_range(0, 15)]}, $urandom(), 0, '0);
        end

        // Address moved mid-stall: error goes sticky, data from original address
        d10 = $urandom() | 32'h1;
        txn(0, 1'b0, 1'b1, 28'h10, d10, 0, '0);
        txn(0, 1'b0, 1'b1, 28'h20, ~d10, 0, '0);
        txn(0, 1'b1, 1'b0, 28'h10, '0, 1, 28'h20);
        repeat (3) @(posedge clk);
        #1;
        check("perr_sticky", {31'b0, err_a}, 32'd1);

        // Reset during the stall of a write drops it
        txn(0, 1'b0, 1'b1, 28'h7, 32'h0, 0, '0);
        txn(0, 1'b1, 1'b0, 28'h10, '0, 0, '0);
        @(negedge clk);
        drive(0, 1'b0, 1'b1, 28'h7, 32'hCAFEF00D);
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("rst_wait", {31'b0, ifa.avs_s0_waitrequest}, 32'd1);
        check("rst_rdata", ifa.avs_s0_readdata, 32'h0);
        check("rst_perr", {31'b0, err_a}, 32'd0);
        for (int s = 0; s < 2; s++) begin
            ref_rd[s]  = '0;
            ref_err[s] = 0;
        end
        drive(0, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        reset = 1'b0;
        txn(0, 1'b1, 1'b0, 28'h7, '0, 0, '0);

        // Read and write together: performed as a write, error flagged
        txn(1, 1'b1, 1'b1, 28'h3, 32'hA5A5A5A5, 0, '0);
        txn(1, 1'b1, 1'b0, 28'h3, '0, 0, '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/avalon_mem_responder.md
# avalon_mem_responder

Synthesizable Avalon-MM slave memory that answers the cache's m0 master port, closing the cache-to-memory path in simulation and on FPGA. It stores data in an internal word-addressed RAM and serves each read or write after a programmable number of stall cycles, signalled with `waitrequest`. It also checks that the master holds its request stable while stalled, and flags violations on a sticky error output.

## Interface
- `ADDR_BITS`, 12: log2 of RAM depth in 32-bit words; index = `avs_s0_address[ADDR_BITS-1:0]`, upper address bits ignored (aliasing).
- `WAIT_CYCLES`, 2: stall cycles inserted before the response cycle; legal range 0..255.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `avs_s0_address` in 28: word address.
- `avs_s0_read` in 1: read request.
- `avs_s0_write` in 1: write request.
- `avs_s0_writedata` in 32: write data.
- `avs_s0_readdata` out 32: read data; valid in the cycle `avs_s0_waitrequest` is low after a read.
- `avs_s0_waitrequest` out 1: low for exactly one cycle per transaction, the completion cycle.
- `protocol_error` out 1: sticky flag; cleared only by reset.

## Operation
- Registered outputs. Reset values:
  - `avs_s0_waitrequest` = 1.
  - `avs_s0_readdata` = 0.
  - `protocol_error` = 0.
  - FSM = IDLE, counter = 0.
- RAM contents are not reset and are undefined until written.
- FSM states:
  - IDLE: waitrequest = 1. On an edge with read or write = 1, latch op, address and writedata, and load counter = WAIT_CYCLES. Go to RESPOND if WAIT_CYCLES = 0, otherwise go to BUSY.
  - BUSY: waitrequest = 1. Decrement the counter each edge. On the edge where counter = 1, go to RESPOND.
  - RESPOND: waitrequest = 0 for one cycle. The unconditional next state is IDLE.
- Entry into RESPOND does the access:
  - Latched write: store the latched writedata at the latched index.
  - Latched read: load `avs_s0_readdata` from the RAM at the latched index. Readdata is held until the next read completes; writes do not change it.
- Read and write both high when sampled in IDLE: treated as a write, and `protocol_error` is set.
- Stability check, in BUSY and RESPOND: any change of read, write or address against the latched values, or of writedata during a write, sets `protocol_error`. The latched transaction still completes unchanged.
- Write then read of the same index returns the new data. Addresses that differ only above `ADDR_BITS` alias to the same word.
- Reset in any state: immediate return to IDLE with reset output values. An in-flight write that has not yet entered RESPOND is dropped.

## Timing
- Request first sampled at edge E0 (IDLE). Waitrequest goes low during the cycle after edge E0+WAIT_CYCLES. The master completes at the following edge, E0+WAIT_CYCLES+1.
- The master holds the request for WAIT_CYCLES+2 cycles.
- One IDLE cycle follows every RESPOND. With back-to-back requests the next one is sampled at E0+WAIT_CYCLES+2, giving a peak rate of 1 transaction per WAIT_CYCLES+2 cycles.
- A request present while in IDLE is never lost: the master keeps it asserted because waitrequest is high.
- Counter width is 8 bits; no wrap occurs within the legal WAIT_CYCLES range.

## Test plan
1. Reset release, no requests, 10 cycles -> waitrequest = 1, readdata = 0x00000000, protocol_error = 0 throughout.
2. WAIT_CYCLES=2: write 0xDEADBEEF to 0x0001000, then read 0x0001000 ->
   - each transaction's waitrequest is low only in the 4th cycle of its request;
   - readdata = 0xDEADBEEF in the read's completion cycle.
3. WAIT_CYCLES=0: write 0x11111111 to index 5, then 0x22222222 to 0x0001005 (aliases index 5 for ADDR_BITS=12), then read 5 ->
   - each transaction completes in its 2nd cycle;
   - readdata = 0x22222222.
4. Address changed from 0x10 to 0x20 mid-BUSY during a read ->
   - protocol_error = 1 from the next cycle and stays set;
   - returned data is RAM[0x10].
5. Reset asserted during BUSY of a write of 0xCAFEF00D to 0x7 (location previously 0x0) ->
   - waitrequest = 1 and readdata = 0 immediately;
   - a subsequent read of 0x7 returns 0x0.
6. Read and write asserted together in IDLE, writedata 0xA5A5A5A5, address 0x3 -> the location is written with 0xA5A5A5A5 and protocol_error = 1.
